// File: rtl/haar_synthesis.sv
// haar_synthesis: multirate Haar reconstruction bank with one shared add/sub accumulator.
// It rebuilds one time-domain sample per accepted en, taking STAGES+1 accumulate clocks per sample.
// Ports:
//   clk        system clock
//   rstN       asynchronous active-low reset
//   en         request the next output sample
//   inStrobes  per-word write strobe for dataIn (STAGES+1 bits)
//   dataIn     packed signed coefficients; word 0 = low-pass, word 1 = coarsest high-pass,
//              word STAGES = finest high-pass
//   dataOut    reconstructed signed sample, held until the next outStrobe
//   outStrobe  one-cycle pulse when dataOut updates
//   busy       accumulation in progress
//   overrun    sticky flag: en arrived while a sample was still in flight
// Build option: define HAAR_SYNTH_SAT_EN to saturate the output. When it is undefined,
// the accumulator is truncated to OUT_WIDTH with two's-complement wrap.
module haar_synthesis #(
    parameter int STAGES         = 4,
    parameter int IN_WIDTH       = 16,
    parameter int INTERNAL_WIDTH = 20,
    parameter int OUT_WIDTH      = 16
) (
    input  logic                              clk,
    input  logic                              rstN,
    input  logic                              en,
    input  logic [STAGES:0]                   inStrobes,
    input  logic [IN_WIDTH*(STAGES+1)-1:0]    dataIn,
    output logic signed [OUT_WIDTH-1:0]       dataOut,
    output logic                              outStrobe,
    output logic                              busy,
    output logic                              overrun
);
    localparam int SW = $clog2(STAGES + 1);

    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                           state, state_nx;
    logic [SW-1:0]                    step, step_nx;
    logic [STAGES-1:0]                c;
    logic signed [IN_WIDTH-1:0]       shadow [STAGES+1];
    logic signed [IN_WIDTH-1:0]       act    [STAGES+1];
    logic signed [IN_WIDTH-1:0]       word   [STAGES+1];
    logic signed [IN_WIDTH-1:0]       act_nx [STAGES+1];
    logic [STAGES:0]                  load;
    logic [STAGES:0]                  neg;
    logic signed [INTERNAL_WIDTH-1:0] acc, acc_nx, term;
    logic signed [OUT_WIDTH-1:0]      narrow;
    logic                             start;

    assign start = (state == IDLE) && en;
    assign busy  = (state == ACC);
    assign term  = INTERNAL_WIDTH'(act[step]);

    for (genvar k = 0; k <= STAGES; k++) begin : g_word
        // Word k refreshes when the low STAGES-k+1 bits of c are zero. For k=0 the mask covers all of c.
        localparam int M = (1 << (STAGES - k + 1)) - 1;
        assign word[k]   = dataIn[k*IN_WIDTH +: IN_WIDTH];
        assign load[k]   = (c & M[STAGES-1:0]) == '0;
        // A strobe on the start cycle writes through to act, bypassing the stale shadow value.
        assign act_nx[k] = (start && load[k]) ? (inStrobes[k] ? word[k] : shadow[k]) : act[k];
        if (k == 0) begin : g_lp
            assign neg[k] = 1'b0;
        end else begin : g_hp
            assign neg[k] = c[STAGES-k];
        end
    end

`ifdef HAAR_SYNTH_SAT_EN
    localparam logic signed [INTERNAL_WIDTH-1:0] MAXV =
        {{(INTERNAL_WIDTH-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [INTERNAL_WIDTH-1:0] MINV = ~MAXV;
    assign narrow = acc > MAXV ? MAXV[OUT_WIDTH-1:0] :
                    acc < MINV ? MINV[OUT_WIDTH-1:0] : acc[OUT_WIDTH-1:0];
`else
    assign narrow = acc[OUT_WIDTH-1:0];
`endif

    always_comb begin
        state_nx = state;
        step_nx  = step;
        acc_nx   = acc;
        if (start) begin
            state_nx = ACC;
            step_nx  = SW'(1);
            acc_nx   = INTERNAL_WIDTH'(act_nx[0]);
        end else if (state == ACC) begin
            acc_nx   = neg[step] ? acc - term : acc + term;
            step_nx  = step + 1'b1;
            state_nx = (step == SW'(STAGES)) ? OUT : ACC;
        end else if (state != IDLE) begin
            state_nx = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state     <= IDLE;
            step      <= '0;
            c         <= '0;
            acc       <= '0;
            dataOut   <= '0;
            outStrobe <= 1'b0;
            overrun   <= 1'b0;
            for (int k = 0; k <= STAGES; k++) begin
                shadow[k] <= '0;
                act[k]    <= '0;
            end
        end else begin
            state     <= state_nx;
            step      <= step_nx;
            acc       <= acc_nx;
            outStrobe <= (state == OUT);
            // The OUT cycle still counts as busy, so only IDLE accepts en.
            overrun   <= overrun | (en && state != IDLE);
            if (state == OUT) begin
                dataOut <= narrow;
                c       <= c + 1'b1;
            end
            for (int k = 0; k <= STAGES; k++) begin
                shadow[k] <= inStrobes[k] ? word[k] : shadow[k];
                act[k]    <= act_nx[k];
            end
        end
    end
endmodule

// File: tb/tb_haar_synthesis.sv
// tb_haar_synthesis: scoreboard bench for haar_synthesis with STAGES=2 and hand-computed samples.
module tb_haar_synthesis;
    localparam int ST = 2;
    localparam int IW = 16;
    localparam int OW = 16;
`ifdef HAAR_SYNTH_SAT_EN
    localparam int SAT_EXP = 32767;
`else
    localparam int SAT_EXP = 24464;
`endif

    typedef struct {int val; int due;} exp_t;

    logic                     clk = 1'b0;
    logic                     rstN = 1'b0;
    logic                     en = 1'b0;
    logic [ST:0]              inStrobes = '0;
    logic [IW*(ST+1)-1:0]     dataIn = '0;
    logic signed [OW-1:0]     dataOut;
    logic                     outStrobe, busy, overrun;
    exp_t                     q[$];
    exp_t                     e;
    int                       cyc = 0;
    int                       total = 0;
    int                       bad = 0;

    haar_synthesis #(.STAGES(ST), .IN_WIDTH(IW), .INTERNAL_WIDTH(20), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rstN(rstN), .en(en), .inStrobes(inStrobes), .dataIn(dataIn),
        .dataOut(dataOut), .outStrobe(outStrobe), .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got != want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: compares every outStrobe against the oldest queued expectation, including its arrival cycle.
    initial forever begin
        @(posedge clk);
        #1;
        cyc++;
        if (outStrobe) begin
            if (q.size() == 0) check("unexpected_strobe", 1, 0);
            else begin
                e = q.pop_front();
                check("sample", int'(dataOut), e.val);
                check("latency", cyc, e.due);
            end
        end else if (q.size() != 0 && cyc > q[0].due) begin
            check("missing_strobe", 0, 1);
            void'(q.pop_front());
        end
    end

    task automatic put(input int k, input int v);
        inStrobes[k] = 1'b1;
        dataIn[k*IW +: IW] = IW'(v);
    endtask

    task automatic clk1;
        @(negedge clk);
        en = 1'b0;
        inStrobes = '0;
    endtask

    // Raise en for one clock, queue the expected sample, then wait out the rest of the gap.
    task automatic sample(input int want, input int gap);
        en = 1'b1;
        q.push_back('{want, cyc + ST + 2});
        clk1();
        check("busy", int'(busy), 1);
        repeat (gap - 1) clk1();
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check("rst_dataOut", int'(dataOut), 0);
        check("rst_outStrobe", int'(outStrobe), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_overrun", int'(overrun), 0);
        rstN = 1'b1;
        clk1();
        // Basic frame
        put(0, 100); put(1, 10); put(2, 3);
        clk1();
        sample(113, 6);
        sample(107, 6);
        put(2, -2);
        clk1();
        sample(88, 6);
        sample(92, 6);
        // Write-through on c=2
        put(2, 3);
        clk1();
        sample(113, 6);
        sample(107, 6);
        put(2, 7);
        sample(97, 6);
        sample(83, 6);
        // Saturation / wrap narrowing
        put(0, 30000); put(1, 30000); put(2, 30000);
        clk1();
        sample(SAT_EXP, 6);
        sample(30000, 6);
        sample(30000, 6);
        sample(-30000, 6);
        check("overrun_idle", int'(overrun), 0);
        // Overrun: second en two clocks after the first
        put(0, 100); put(1, 10); put(2, 3);
        clk1();
        en = 1'b1;
        q.push_back('{113, cyc + ST + 2});
        clk1();
        clk1();
        en = 1'b1;
        clk1();
        repeat (4) clk1();
        check("overrun_set", int'(overrun), 1);
        sample(107, 6);
        check("overrun_sticky", int'(overrun), 1);
        // Reset mid-sample
        en = 1'b1;
        clk1();
        clk1();
        rstN = 1'b0;
        #1;
        check("abort_dataOut", int'(dataOut), 0);
        check("abort_busy", int'(busy), 0);
        check("abort_overrun", int'(overrun), 0);
        check("abort_outStrobe", int'(outStrobe), 0);
        clk1();
        clk1();
        rstN = 1'b1;
        clk1();
        // Wrap over nine samples, with act[0]/act[1] reloading only at c=0
        put(0, 100); put(1, 10); put(2, 3);
        clk1();
        sample(113, 6);
        put(0, 200); put(1, 20);
        clk1();
        sample(107, 6);
        sample(93, 6);
        sample(87, 6);
        sample(223, 6);
        sample(217, 6);
        put(0, 300); put(1, 30);
        clk1();
        sample(183, 6);
        sample(177, 6);
        sample(333, 6);
        repeat (6) clk1();
        check("queue_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/haar_synthesis.md
# haar_synthesis

- Multirate Haar synthesis (reconstruction) bank.
- Inverse of the team's Haar analysis bank: consumes its low-pass word and STAGES high-pass words in the same packed array and strobe layout, and rebuilds one time-domain sample per `en`.
- Uses one shared add/sub accumulator, sequenced over STAGES+1 clocks per sample, to save resources.
- Sits on the playback path after any coefficient processing (thresholding, quantisation).

## Interface
Parameters:
- STAGES, 4, number of filter levels; frame = 2^STAGES output samples
- IN_WIDTH, 16, signed coefficient word width
- INTERNAL_WIDTH, 20, accumulator width; must be ≥ IN_WIDTH + clog2(STAGES+1)
- OUT_WIDTH, 16, signed output sample width

Ports:
- clk  input  1  system clock
- rstN  input  1  reset, asynchronous, active low
- en  input  1  request next output sample (one per output sample period)
- inStrobes  input  STAGES+1  per-word write strobe for dataIn
- dataIn  input  IN_WIDTH*(STAGES+1)  packed signed coefficients, little-endian: word 0 = low-pass, word 1 = coarsest high-pass, word STAGES = finest high-pass
- dataOut  output  OUT_WIDTH  reconstructed signed sample
- outStrobe  output  1  one-cycle pulse, dataOut valid/updated
- busy  output  1  accumulation in progress
- overrun  output  1  sticky: `en` arrived while busy

## Operation
- Shadow registers shadow[k], k=0..STAGES, are written from dataIn word k on any cycle with inStrobes[k]=1, independent of other activity.
- Active registers act[k] feed the accumulator. They transfer from shadow only on the first cycle of a sample.
- Frame counter c, STAGES bits, reset 0, increments modulo 2^STAGES at the end of each accepted sample.
- Transfer rules, on the start cycle of sample c:
  - act[0] loads when c == 0.
  - act[k], k≥1, loads when the low (STAGES-k+1) bits of c are all zero.
  - If inStrobes[k] is asserted in the same cycle, act[k] takes the incoming dataIn word (write-through), not the old shadow value.
- Reconstruction: x[c] = act[0] + Σ_{k=1..STAGES} s_k·act[k].
  - s_k = +1 if bit (STAGES-k) of c is 0, else −1.
  - All terms are sign-extended to INTERNAL_WIDTH.
  - This inverts analysis LPF = (a+b)/2, HPF = (a−b)/2.
- State machine:
  - IDLE: on `en`, go to ACC with step=0. Do the transfers, acc ← act[0] (post-transfer value), busy=1.
  - ACC, step j=1..STAGES: acc ← acc ± act[j]. After step STAGES, go to OUT.
  - OUT: dataOut ← narrow(acc), outStrobe=1, c ← c+1, busy=0, return to IDLE.
- `en` while busy: ignored (no queueing), overrun ← 1. `en` in the OUT cycle also counts as busy.
- Narrowing: see Configuration.
- Reset values: dataOut=0, outStrobe=0, busy=0, overrun=0, c=0, all shadow/act/acc=0, state IDLE.
- Reset asserted mid-accumulation aborts the sample: no outStrobe, c stays 0 after release.
- overrun clears only on reset.

## Timing
- `en` sampled at edge T → outStrobe high during the cycle after edge T+STAGES+1; dataOut valid from that point.
- Latency is STAGES+2 edges from the `en` edge to the registered output.
- Minimum `en` spacing: STAGES+2 clocks; any closer `en` sets overrun.
- dataOut holds its value until the next outStrobe.
- inStrobes are accepted every cycle; a write lands in shadow at the strobe edge.

## Configuration
- HAAR_SYNTH_SAT_EN defined: acc is saturated to the OUT_WIDTH signed range [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1].
- Undefined: dataOut = acc[OUT_WIDTH−1:0] (two's-complement wrap), and no saturation logic is built.

## Test plan
- Bench setup for all scenarios: STAGES=2 (frame of 4), IN_WIDTH=16, OUT_WIDTH=16, INTERNAL_WIDTH=20.
1. Basic frame:
   - Stimulus: strobe word0=100, word1=10, word2=3; four `en` pulses 6 clocks apart; re-strobe word2=−2 between samples 1 and 2.
   - Required: dataOut 113, 107, 88, 92; each outStrobe exactly 4 edges after its `en`.
2. Write-through:
   - Stimulus: word2 strobed =7 on the same cycle as the `en` for c=2 (prior shadow 3).
   - Required: sample uses 7, e.g. 100−10+7=97.
3. Overrun:
   - Stimulus: second `en` 2 clocks after the first.
   - Required: only one outStrobe; overrun=1 and stays 1; c advances by 1.
4. Saturation (macro defined):
   - Stimulus: word0=30000, word1=30000, word2=30000 at c=0.
   - Required: dataOut=32767. With the macro undefined: dataOut=90000 mod 2^16 as signed = 24464.
5. Reset mid-sample:
   - Stimulus: drop rstN 2 clocks after `en`.
   - Required: no outStrobe; dataOut=0, busy=0, overrun=0; next frame starts at c=0.
6. Wrap:
   - Stimulus: run 9 samples.
   - Required: c wraps 3→0; act[0]/act[1] reload only at samples 0, 4, 8.
